// File: rtl/apb_pwm_multi.sv
// Multi-channel PWM generator with an APB register slave.
// One shared period counter drives NCH channels; period/duty are double-buffered and load only at a period boundary.
module apb_pwm_multi #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [11:0]     PADDR,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  output logic [NCH-1:0]  pwm_out,
  output logic            irq
);

  localparam logic [9:0] IDX_CTRL   = 10'd0;
  localparam logic [9:0] IDX_PERIOD = 10'd1;
  localparam logic [9:0] IDX_STATUS = 10'd2;
  localparam logic [9:0] IDX_COUNT  = 10'd3;

  logic [9:0]     idx;
  logic           wr;
  logic           mapped;
  logic           ctrl_wr;
  logic           period_wr;
  logic           status_wr;
  logic [NCH-1:0] duty_wr;

  logic [NCH-1:0] en;
  logic [NCH-1:0] en_next;
  logic           irq_en;
  logic [CW-1:0]  period_stg;
  logic [CW-1:0]  duty_stg [NCH];
  logic [CW-1:0]  period_act;
  logic [CW-1:0]  duty_act [NCH];
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           wrap_flag;
  logic           run;
  logic           wrapping;
  logic           load;
  logic [31:0]    rdata;
  logic           unused_bits;

  assign idx       = PADDR[11:2];
  assign wr        = PSEL & PENABLE & PWRITE;
  assign mapped    = idx < 10'(4 + NCH);
  assign ctrl_wr   = wr && (idx == IDX_CTRL);
  assign period_wr = wr && (idx == IDX_PERIOD);
  assign status_wr = wr && (idx == IDX_STATUS);

  always_comb begin
    duty_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_wr[i] = wr && (idx == 10'(4 + i));
    end
  end

  assign run      = |en;
  assign wrapping = run && (cnt == period_act);
  assign load     = !run || wrapping;
  assign en_next  = ctrl_wr ? PWDATA[NCH-1:0] : en;

  // A write that clears every enable zeroes the counter at that same edge,
  // while a fresh enable starts the count from 0 one cycle later.
  always_comb begin
    cnt_next = '0;
    if (run && (|en_next)) begin
      cnt_next = wrapping ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en         <= '0;
      irq_en     <= 1'b0;
      period_stg <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_stg[i] <= '0;
      end
    end else begin
      if (ctrl_wr) begin
        en     <= PWDATA[NCH-1:0];
        irq_en <= PWDATA[31];
      end
      if (period_wr) begin
        period_stg <= PWDATA[CW-1:0];
      end
      for (int i = 0; i < NCH; i++) begin
        if (duty_wr[i]) begin
          duty_stg[i] <= PWDATA[CW-1:0];
        end
      end
    end
  end

  // Active copies sample the staging values from before this edge, so a
  // staging write landing on a wrap edge is picked up only at the next wrap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      period_act <= '0;
      cnt        <= '0;
      wrap_flag  <= 1'b0;
      pwm_out    <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_act[i] <= '0;
      end
    end else begin
      cnt <= cnt_next;
      if (load) begin
        period_act <= period_stg;
        for (int i = 0; i < NCH; i++) begin
          duty_act[i] <= duty_stg[i];
        end
      end
      if (wrapping) begin
        wrap_flag <= 1'b1;
      end else if (status_wr && PWDATA[0]) begin
        wrap_flag <= 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        pwm_out[i] <= en[i] & (cnt < duty_act[i]);
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CTRL:   rdata = {irq_en, 31'(en)};
      IDX_PERIOD: rdata = 32'(period_stg);
      IDX_STATUS: rdata = {31'b0, wrap_flag};
      IDX_COUNT:  rdata = 32'(cnt);
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (idx == 10'(4 + i)) begin
            rdata = 32'(duty_stg[i]);
          end
        end
      end
    endcase
  end

  assign PRDATA      = (PSEL && !PWRITE) ? rdata : 32'b0;
  assign PREADY      = 1'b1;
  assign PSLVERR     = PSEL & PENABLE & ~mapped;
  assign irq         = wrap_flag & irq_en;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

endmodule

// File: tb/tb_apb_pwm_multi.sv
// Self-checking bench for apb_pwm_multi: cycle-level reference model plus directed scenarios.
module tb_apb_pwm_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b1;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [11:0] PADDR   = '0;
  logic [31:0] PWDATA  = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [NCH-1:0] pwm_out;
  logic        irq;

  int errors = 0;
  int checks = 0;

  apb_pwm_multi #(.NCH(NCH), .CW(CW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .pwm_out(pwm_out), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: architectural registers updated by the rules of the block.
  logic [3:0] mEn = '0;
  logic       mIrqEn = 1'b0;
  int         mPerStg = 0, mPer = 0, mCnt = 0;
  int         mDutyStg [4] = '{default: 0};
  int         mDuty [4] = '{default: 0};
  bit         mWrap = 1'b0;
  logic [3:0] mPwm = '0;

  always @(posedge PCLK or negedge PRESETn) begin : model
    int a;
    bit w, running, wrapNow;
    logic [3:0] enAfter, pwmNext;
    if (!PRESETn) begin
      mEn = '0; mIrqEn = 1'b0; mPerStg = 0; mPer = 0; mCnt = 0; mWrap = 1'b0; mPwm = '0;
      for (int i = 0; i < 4; i++) begin
        mDutyStg[i] = 0;
        mDuty[i] = 0;
      end
    end else begin
      a = int'(PADDR[11:2]);
      w = PSEL && PENABLE && PWRITE;
      running = (mEn != 0);
      wrapNow = running && (mCnt == mPer);
      for (int i = 0; i < 4; i++) pwmNext[i] = mEn[i] && (mCnt < mDuty[i]);
      enAfter = (w && a == 0) ? PWDATA[3:0] : mEn;
      if (running && enAfter != 0) mCnt = wrapNow ? 0 : ((mCnt + 1) % 65536);
      else mCnt = 0;
      if (!running || wrapNow) begin
        mPer = mPerStg;
        for (int i = 0; i < 4; i++) mDuty[i] = mDutyStg[i];
      end
      if (wrapNow) mWrap = 1'b1;
      else if (w && a == 2 && PWDATA[0]) mWrap = 1'b0;
      if (w) begin
        if (a == 0) begin
          mEn = PWDATA[3:0];
          mIrqEn = PWDATA[31];
        end
        if (a == 1) mPerStg = int'(PWDATA[15:0]);
        if (a >= 4 && a < 8) mDutyStg[a-4] = int'(PWDATA[15:0]);
      end
      mPwm = pwmNext;
    end
  end

  function automatic logic [31:0] expRead();
    int a;
    a = int'(PADDR[11:2]);
    if (!(PSEL && !PWRITE)) return 32'h0;
    if (a == 0) return {mIrqEn, 27'b0, mEn};
    if (a == 1) return 32'(mPerStg);
    if (a == 2) return {31'b0, mWrap};
    if (a == 3) return 32'(mCnt);
    if (a >= 4 && a < 8) return 32'(mDutyStg[a-4]);
    return 32'h0;
  endfunction

  always @(negedge PCLK) begin
    checkOutput("pwm_out", 32'(pwm_out), 32'(mPwm));
    checkOutput("irq", 32'(irq), 32'(mWrap && mIrqEn));
    checkOutput("PSLVERR", 32'(PSLVERR), 32'(PSEL && PENABLE && (PADDR[11:2] >= 10'd8)));
    checkOutput("PRDATA", PRDATA, expRead());
    checkOutput("PREADY", 32'(PREADY), 32'h1);
  end

  // High-pulse widths of channel 0, recorded as each pulse ends.
  int widths[$];
  int runLen = 0;
  always @(negedge PCLK) begin
    if (pwm_out[0]) runLen++;
    else if (runLen > 0) begin
      widths.push_back(runLen);
      runLen = 0;
    end
  end

  function automatic int getW(input int k);
    return (widths.size() > k) ? widths[k] : -1;
  endfunction

  // All bus tasks start just after a rising edge; a write commits two edges later.
  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
  endtask

  task automatic apbRead(input logic [11:0] a, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1;
    d = PRDATA;
    PSEL = 1'b0; PADDR = '0;
  endtask

  task automatic waitRise0(output bit ok);
    logic prev;
    ok = 1'b0;
    @(negedge PCLK);
    prev = pwm_out[0];
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge PCLK);
      if (pwm_out[0] && !prev) ok = 1'b1;
      prev = pwm_out[0];
    end
    checkOutput("pwm0_rise_seen", 32'(ok), 32'h1);
  endtask

  task automatic waitIrq(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge PCLK);
      if (irq) ok = 1'b1;
    end
    checkOutput("irq_seen", 32'(ok), 32'h1);
  endtask

  initial begin : watchdog
    #1500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [31:0] d;
    logic err;
    bit ok;
    int hi [4];
    logic [9:0] seen;

    #1 PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("rst_pwm", 32'(pwm_out), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_slverr", 32'(PSLVERR), 32'h0);
    checkOutput("rst_prdata", PRDATA, 32'h0);
    PRESETn = 1'b1;
    for (int r = 0; r < 8; r++) begin
      apbRead(12'(r * 4), d, err);
      checkOutput("rst_reg", d, 32'h0);
    end
    apbRead(12'h050, d, err);
    checkOutput("unmapped_slverr", 32'(err), 32'h1);
    checkOutput("unmapped_data", d, 32'h0);

    $display("[TB] basic PWM");
    applyStimulus(12'h004, 32'd9);
    applyStimulus(12'h010, 32'd3);
    applyStimulus(12'h014, 32'd0);
    applyStimulus(12'h018, 32'd12);
    applyStimulus(12'h000, 32'h7);
    hi = '{default: 0};
    @(posedge PCLK);
    repeat (30) begin
      @(negedge PCLK);
      for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
    end
    checkOutput("ch0_high_cycles", 32'(hi[0]), 32'd9);
    checkOutput("ch1_high_cycles", 32'(hi[1]), 32'd0);
    checkOutput("ch2_high_cycles", 32'(hi[2]), 32'd30);
    checkOutput("ch3_high_cycles", 32'(hi[3]), 32'd0);
    @(posedge PCLK); #1;
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      peek(12'h00C, d);
      if (d < 10) seen[d[3:0]] = 1'b1;
      @(posedge PCLK); #1;
    end
    checkOutput("count_covers_0_to_9", 32'(seen), 32'h3FF);

    $display("[TB] glitch-free duty update");
    waitRise0(ok);
    widths.delete();
    @(posedge PCLK); #1;
    applyStimulus(12'h010, 32'd7);
    repeat (25) @(posedge PCLK);
    #1;
    checkOutput("pulse_current", 32'(getW(0)), 32'd3);
    checkOutput("pulse_next", 32'(getW(1)), 32'd7);
    waitRise0(ok);
    widths.delete();
    repeat (7) @(posedge PCLK);
    #1;
    applyStimulus(12'h010, 32'd3);
    repeat (30) @(posedge PCLK);
    #1;
    checkOutput("pulse_after_wrap_write", 32'(getW(1)), 32'd7);
    checkOutput("pulse_deferred", 32'(getW(2)), 32'd3);

    $display("[TB] disable mid-period");
    applyStimulus(12'h000, 32'h0);
    checkOutput("disable_pwm_still_on", 32'(pwm_out[2]), 32'h1);
    peek(12'h00C, d);
    checkOutput("disable_count_zero", d, 32'h0);
    @(posedge PCLK); #1;
    checkOutput("disable_pwm_off", 32'(pwm_out), 32'h0);

    $display("[TB] asynchronous reset");
    applyStimulus(12'h000, 32'h7);
    repeat (5) @(posedge PCLK);
    #1;
    #1 PRESETn = 1'b0;
    #1;
    checkOutput("async_rst_pwm", 32'(pwm_out), 32'h0);
    checkOutput("async_rst_irq", 32'(irq), 32'h0);
    peek(12'h00C, d);
    checkOutput("async_rst_count", d, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apbRead(12'h000, d, err);
    checkOutput("async_rst_ctrl", d, 32'h0);
    apbRead(12'h018, d, err);
    checkOutput("async_rst_duty2", d, 32'h0);

    $display("[TB] WRAP and irq");
    applyStimulus(12'h004, 32'd9);
    applyStimulus(12'h010, 32'd3);
    applyStimulus(12'h000, 32'h8000_0001);
    waitIrq(ok);
    @(posedge PCLK); #1;
    apbRead(12'h008, d, err);
    checkOutput("status_wrap_set", d, 32'h1);
    checkOutput("irq_high", 32'(irq), 32'h1);
    applyStimulus(12'h008, 32'h1);
    peek(12'h008, d);
    checkOutput("status_cleared", d, 32'h0);
    checkOutput("irq_cleared", 32'(irq), 32'h0);
    waitIrq(ok);
    repeat (8) @(posedge PCLK);
    #1;
    applyStimulus(12'h008, 32'h1);
    peek(12'h008, d);
    checkOutput("clear_on_wrap_set_wins", d, 32'h1);

    $display("[TB] period zero");
    applyStimulus(12'h000, 32'h0);
    applyStimulus(12'h004, 32'd0);
    applyStimulus(12'h010, 32'd1);
    applyStimulus(12'h000, 32'h1);
    repeat (2) @(posedge PCLK);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("p0_pwm0_high", 32'(pwm_out[0]), 32'h1);
      applyStimulus(12'h008, 32'h1);
      peek(12'h008, d);
      checkOutput("p0_wrap_every_cycle", d, 32'h1);
    end

    $display("[TB] full-width period");
    applyStimulus(12'h000, 32'h0);
    applyStimulus(12'h008, 32'h1);
    applyStimulus(12'h004, 32'h0001_FFFF);
    applyStimulus(12'h000, 32'h1);
    repeat (65535) @(posedge PCLK);
    #1;
    peek(12'h00C, d);
    checkOutput("max_count", d, 32'h0000_FFFF);
    peek(12'h008, d);
    checkOutput("max_no_wrap_yet", d, 32'h0);
    @(posedge PCLK); #1;
    peek(12'h00C, d);
    checkOutput("max_wrapped_count", d, 32'h0);
    peek(12'h008, d);
    checkOutput("max_wrap_set", d, 32'h1);

    @(posedge PCLK); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
